// File: rtl/bc_uart_tx.sv
// bc_uart_tx - serial transmitter with a 16-byte FIFO.
//
// Frame format is fixed: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// Every bit lasts 16 baud16x_ce pulses, so this block shares its baud enable
// with the matching receiver.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   baud16x_ce one-clk pulse at 16x the baud rate
//   wr, di     host write strobe and byte to transmit
//   clear      synchronous flush: empties FIFO, aborts frame, clears over_run
//   cts_n      clear-to-send, active-low, asynchronous to clk
//   sout       serial line output, idles high
//   busy       a frame is in progress
//   empty/full FIFO holds 0 / 16 bytes
//   level      FIFO occupancy 0..16
//   over_run   sticky flag, set when a write is attempted while full
module bc_uart_tx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud16x_ce,
  input  logic       wr,
  input  logic [7:0] di,
  input  logic       clear,
  input  logic       cts_n,
  output logic       sout,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic [4:0] level,
  output logic       over_run
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0] mem_q [16];
  logic [3:0] wr_ptr_q;
  logic [3:0] rd_ptr_q;
  logic [4:0] level_q;
  logic [4:0] level_d;
  logic       over_run_q;

  // cts_n synchronizer
  logic       cts_meta_q;
  logic       cts_s_q;

  // Frame engine
  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] samp_cnt_q;
  logic       sout_q;

  logic       full_w;
  logic       empty_w;
  logic       push;
  logic       pop;
  logic       bit_end;

  assign full_w  = (level_q == 5'd16);
  assign empty_w = (level_q == 5'd0);

  // clear overrides both sides, so a write in the same cycle is dropped.
  assign push    = wr && !full_w && !clear;
  // Starting a frame is the only consumer of the FIFO; it is not gated by
  // the baud enable, so a new frame begins on the first edge it is allowed.
  assign pop     = (state_q == IDLE) && !empty_w && !cts_s_q && !clear;
  // The sample counter sits at 15 on the last pulse of each bit period.
  assign bit_end = baud16x_ce && (samp_cnt_q == 4'd15);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  // Data array has no reset; contents are only meaningful below level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= di;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= 4'd0;
      rd_ptr_q   <= 4'd0;
      level_q    <= 5'd0;
      over_run_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= 4'd0;
      rd_ptr_q   <= 4'd0;
      level_q    <= 5'd0;
      over_run_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
      level_q <= level_d;
      // Judged on the pre-edge full flag, even if a pop frees a slot now.
      if (wr && full_w) over_run_q <= 1'b1;
    end
  end

  // Flops reset to 1 so the line is treated as not-clear-to-send until
  // the real cts_n level has propagated through both stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_s_q    <= cts_meta_q;
    end
  end

  // Frame state machine. cts is only consulted in IDLE, so a frame that has
  // started always runs to its stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      samp_cnt_q <= 4'd0;
      sout_q     <= 1'b1;
    end else if (clear) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      samp_cnt_q <= 4'd0;
      sout_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            sout_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            samp_cnt_q <= 4'd0;
            state_q    <= START;
          end else begin
            sout_q <= 1'b1;
          end
        end
        START: begin
          if (baud16x_ce) samp_cnt_q <= samp_cnt_q + 4'd1;
          if (bit_end) begin
            sout_q  <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud16x_ce) samp_cnt_q <= samp_cnt_q + 4'd1;
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              sout_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              sout_q    <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud16x_ce) samp_cnt_q <= samp_cnt_q + 4'd1;
          if (bit_end) begin
            sout_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          sout_q  <= 1'b1;
        end
      endcase
    end
  end

  assign sout     = sout_q;
  assign busy     = (state_q != IDLE);
  assign empty    = empty_w;
  assign full     = full_w;
  assign level    = level_q;
  assign over_run = over_run_q;

endmodule
